// File: rtl/hci_system_pkg.sv
// Shared definitions for the HCI config path: register map, STATUS layout and bank FSM states.
package hci_system_pkg;

    localparam int unsigned MAX_N_DATAMOVERS = 4;
    localparam int unsigned ID_PERIPH        = 8;
    localparam int unsigned PERIPH_SEL_WIDTH = $clog2(MAX_N_DATAMOVERS);

    // Register word indices within a bank (byte offset = index * 4).
    localparam int unsigned REG_TRIGGER    = 0;
    localparam int unsigned REG_STATUS     = 1;
    localparam int unsigned REG_SOFT_CLEAR = 2;
    localparam int unsigned REG_DONE_CNT   = 3;
    localparam int unsigned REG_CFG0       = 4;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        err;
        logic        busy;
    } status_t;

    typedef enum logic {
        IDLE,
        RUNNING
    } bank_state_e;

endpackage

// File: rtl/hci_periph_ctrl_bank.sv
// One datamover register bank: job FSM, start pulse, sticky error, done counter and config regs.
module hci_periph_ctrl_bank
    import hci_system_pkg::*;
#(
    parameter int unsigned N_REGS = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         trig_i,
    input  logic                         clr_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(N_REGS)-1:0]    cfg_idx_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  wdata_i,
    input  logic                         done_i,
    output logic                         start_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [7:0]                   done_cnt_o,
    output logic [(N_REGS-4)*32-1:0]     cfg_o
);

    bank_state_e                  state_q;
    logic                         start_q;
    logic                         err_q;
    logic [7:0]                   cnt_q;
    logic [(N_REGS-4)*32-1:0]     cfg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            cfg_q   <= '0;
        end else begin
            start_q <= 1'b0;
            if (clr_i) begin
                // Soft clear overrides a coincident done_i.
                state_q <= IDLE;
                err_q   <= 1'b0;
                cnt_q   <= 8'd0;
                cfg_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (trig_i) begin
                            state_q <= RUNNING;
                            start_q <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (done_i) begin
                            state_q <= IDLE;
                            cnt_q   <= cnt_q + 8'd1;
                        end
                        if (trig_i) err_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
                if (cfg_we_i) begin
                    if (state_q == RUNNING) begin
                        err_q <= 1'b1;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_i[b]) begin
                                cfg_q[(int'(cfg_idx_i) - 4) * 32 + 8 * b +: 8] <= wdata_i[8 * b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign start_o    = start_q;
    assign busy_o     = (state_q == RUNNING);
    assign err_o      = err_q;
    assign done_cnt_o = cnt_q;
    assign cfg_o      = cfg_q;

endmodule

// File: rtl/hci_periph_ctrl_slave.sv
// Peripheral-bus config target: decodes word accesses into per-datamover banks and returns
// registered responses one cycle after each grant.
module hci_periph_ctrl_slave
    import hci_system_pkg::*;
#(
    parameter int unsigned N_DATAMOVERS = MAX_N_DATAMOVERS,
    parameter int unsigned N_REGS       = 16,
    parameter int unsigned ID_WIDTH     = ID_PERIPH,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic [31:0]                           add_i,
    input  logic                                  wen_i,
    input  logic [3:0]                            be_i,
    input  logic [31:0]                           data_i,
    input  logic [ID_WIDTH-1:0]                   id_i,
    output logic [31:0]                           r_data_o,
    output logic                                  r_valid_o,
    output logic [ID_WIDTH-1:0]                   r_id_o,
    output logic [N_DATAMOVERS-1:0]               start_o,
    output logic [N_DATAMOVERS-1:0]               busy_o,
    input  logic [N_DATAMOVERS-1:0]               done_i,
    output logic [N_DATAMOVERS*(N_REGS-4)*32-1:0] cfg_o
);

    localparam int unsigned RegW       = $clog2(N_REGS);
    localparam int unsigned NCfg       = N_REGS - 4;
    localparam logic [31:0] RangeBytes = 32'(N_DATAMOVERS * N_REGS * 4);

    logic [31:0]                 off;
    logic [RegW-1:0]             reg_idx;
    logic [PERIPH_SEL_WIDTH-1:0] bank_idx;
    logic                        in_range;
    logic                        wr_acc;

    assign off      = add_i - BASE_ADDR;
    assign reg_idx  = off[2 +: RegW];
    assign bank_idx = off[2 + RegW +: PERIPH_SEL_WIDTH];
    assign in_range = (off < RangeBytes);
    assign wr_acc   = req_i && !wen_i && in_range;
    assign gnt_o    = req_i;

    logic [N_DATAMOVERS-1:0] err;
    logic [7:0]              cnt [N_DATAMOVERS];

    for (genvar i = 0; i < N_DATAMOVERS; i++) begin : g_bank
        logic sel;
        assign sel = wr_acc && (32'(bank_idx) == i);

        hci_periph_ctrl_bank #(
            .N_REGS(N_REGS)
        ) u_bank (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .trig_i     (sel && (32'(reg_idx) == REG_TRIGGER)),
            .clr_i      (sel && (32'(reg_idx) == REG_SOFT_CLEAR)),
            .cfg_we_i   (sel && (32'(reg_idx) >= REG_CFG0)),
            .cfg_idx_i  (reg_idx),
            .be_i       (be_i),
            .wdata_i    (data_i),
            .done_i     (done_i[i]),
            .start_o    (start_o[i]),
            .busy_o     (busy_o[i]),
            .err_o      (err[i]),
            .done_cnt_o (cnt[i]),
            .cfg_o      (cfg_o[i * NCfg * 32 +: NCfg * 32])
        );
    end

    logic [31:0]        rdata;
    logic               sel_busy;
    logic               sel_err;
    logic [7:0]         sel_cnt;
    logic [NCfg*32-1:0] sel_cfg;
    status_t            status;

    always_comb begin
        sel_busy = 1'b0;
        sel_err  = 1'b0;
        sel_cnt  = 8'd0;
        sel_cfg  = '0;
        for (int unsigned i = 0; i < N_DATAMOVERS; i++) begin
            if (32'(bank_idx) == i) begin
                sel_busy = busy_o[i];
                sel_err  = err[i];
                sel_cnt  = cnt[i];
                sel_cfg  = cfg_o[i * NCfg * 32 +: NCfg * 32];
            end
        end
        status      = '0;
        status.busy = sel_busy;
        status.err  = sel_err;
        rdata       = 32'd0;
        if (in_range) begin
            if (32'(reg_idx) == REG_STATUS) begin
                rdata = status;
            end else if (32'(reg_idx) == REG_DONE_CNT) begin
                rdata = {24'd0, sel_cnt};
            end else if (32'(reg_idx) >= REG_CFG0) begin
                rdata = sel_cfg[(32'(reg_idx) - REG_CFG0) * 32 +: 32];
            end
        end
    end

    logic                r_valid_q;
    logic [ID_WIDTH-1:0] r_id_q;
    logic [31:0]         r_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= 32'd0;
        end else begin
            r_valid_q <= req_i;
            if (req_i) begin
                r_id_q   <= id_i;
                r_data_q <= wen_i ? rdata : 32'd0;
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    assign r_data_o  = r_data_q;

endmodule
